// File: rtl/invo_freq_meter.sv
// rtl/invo_freq_meter.sv - ring-oscillator bank controller and per-channel edge counter
module invo_freq_meter #(
    parameter int NCH         = 4,
    parameter int CW          = 32,
    parameter int WIN_W       = 16,
    parameter int SETTLE      = 5,
    parameter int SYNC_STAGES = 2,
    localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [CHW-1:0]   CH_SEL,
    input  logic [WIN_W-1:0] WINDOW,
    input  logic [NCH-1:0]   OSC_IN,
    output logic [NCH-1:0]   INIT_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [CW-1:0]    COUNT,
    output logic             OVF
);

    // One down-counter times every phase, so it must hold the widest of them.
    localparam int TA = $clog2(SETTLE + SYNC_STAGES + 2);
    localparam int TW = (WIN_W > TA) ? WIN_W : TA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_ARM,
        S_MEAS,
        S_REPORT
    } state_t;

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [CHW-1:0]     ch_q;
    logic [WIN_W-1:0]   win_q;
    logic [CW-1:0]      count_q;
    logic               ovf_q;
    logic [NCH-1:0]     sync_q [SYNC_STAGES];
    logic [NCH-1:0]     hist_q;
    logic [NCH-1:0]     rise;
    logic [NCH-1:0]     sel_mask;
    logic               sel_edge;
    logic               accept;
    logic               released;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= OSC_IN;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    // An out-of-range channel number decodes to an empty mask: nothing released, nothing counted.
    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < NCH; i++) begin
            sel_mask[i] = (ch_q == CHW'(i));
        end
    end

    assign sel_edge = |(rise & sel_mask);
    assign accept   = (state_q == S_IDLE) && START;
    assign released = (state_q == S_ARM) || (state_q == S_MEAS);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    if (SETTLE > 0) begin
                        state_d = S_HOLD;
                        timer_d = TW'(SETTLE - 1);
                    end else begin
                        state_d = S_ARM;
                        timer_d = TW'(SYNC_STAGES);
                    end
                end
            end
            S_HOLD: begin
                if (timer_q == '0) begin
                    state_d = S_ARM;
                    timer_d = TW'(SYNC_STAGES);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_ARM: begin
                // SYNC_STAGES+1 cycles lets the pipeline flush samples taken while INIT was held.
                if (timer_q == '0) begin
                    state_d = (win_q == '0) ? S_REPORT : S_MEAS;
                    timer_d = TW'(win_q) - 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_MEAS: begin
                if (timer_q == '0) begin
                    state_d = S_REPORT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ch_q    <= '0;
            win_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            ch_q    <= CH_SEL;
            win_q   <= WINDOW;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if ((state_q == S_MEAS) && sel_edge) begin
            if (&count_q) begin
                ovf_q <= 1'b1;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign INIT_OUT = ~(sel_mask & {NCH{released}});
    assign BUSY     = (state_q != S_IDLE);
    assign DONE     = (state_q == S_REPORT);
    assign COUNT    = count_q;
    assign OVF      = ovf_q;

endmodule

// File: tb/tb_invo_freq_meter.sv
// tb/tb_invo_freq_meter.sv - directed self-checking bench for invo_freq_meter
module tb_invo_freq_meter;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        start1, start2;
    logic [1:0]  ch1, ch2;
    logic [15:0] win1, win2;
    logic [3:0]  osc = 4'h0;
    logic [3:0]  init1, init2;
    logic        busy1, busy2, done1, done2, ovf1, ovf2;
    logic [31:0] count1;
    logic [3:0]  count2;

    int per [4];
    int cyc = 0;
    int passed = 0;
    int total = 0;

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        cyc++;
        for (int i = 0; i < 4; i++) begin
            osc[i] = (per[i] == 0) ? 1'b0 : ((cyc % per[i]) < (per[i] / 2));
        end
    end

    invo_freq_meter u_dut (
        .CLK(CLK), .RESET_N(rst_n), .START(start1), .CH_SEL(ch1), .WINDOW(win1),
        .OSC_IN(osc), .INIT_OUT(init1), .BUSY(busy1), .DONE(done1),
        .COUNT(count1), .OVF(ovf1)
    );

    invo_freq_meter #(.CW(4)) u_sat (
        .CLK(CLK), .RESET_N(rst_n), .START(start2), .CH_SEL(ch2), .WINDOW(win2),
        .OSC_IN(osc), .INIT_OUT(init2), .BUSY(busy2), .DONE(done2),
        .COUNT(count2), .OVF(ovf2)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_ctl(input bit use2, input logic s, input logic [1:0] ch, input logic [15:0] win);
        if (use2) begin
            start2 = s; ch2 = ch; win2 = win;
        end else begin
            start1 = s; ch1 = ch; win1 = win;
        end
    endtask

    // Raises START for one cycle, then watches DONE and INIT_OUT; optional disturbances while busy
    // and a START held during the REPORT cycle, both of which must be ignored.
    task automatic run(input bit use2, input logic [1:0] ch, input logic [15:0] win,
                       input bit noise, input bit rpt,
                       output int lat, output int ndone, output int init_bad);
        logic [3:0] exp_init;
        logic [3:0] got_init;
        logic       d;
        int         rpt_n;
        lat = -1; ndone = 0; init_bad = 0; rpt_n = -1;
        set_ctl(use2, 1'b1, ch, win);
        for (int n = 1; n <= 400; n++) begin
            tick();
            if (n == 1) set_ctl(use2, 1'b0, ch, win);
            if (noise && (n == 20 || n == 60)) set_ctl(use2, 1'b1, ~ch, 16'd7);
            if (noise && (n == 21 || n == 61)) set_ctl(use2, 1'b0, ~ch, 16'd7);
            if (n == rpt_n) set_ctl(use2, 1'b0, ch, win);
            d        = use2 ? done2 : done1;
            got_init = use2 ? init2 : init1;
            exp_init = 4'hF;
            if (n >= 6 && n <= 8 + int'(win)) exp_init[ch] = 1'b0;
            if (got_init !== exp_init) init_bad++;
            if (d === 1'b1) begin
                ndone++;
                if (lat < 0) begin
                    lat = n;
                    if (rpt) begin
                        set_ctl(use2, 1'b1, ch, win);
                        rpt_n = n + 1;
                    end
                end
            end
            if (lat > 0 && n >= lat + 20) break;
        end
    endtask

    int lat, nd, bad;

    initial begin
        rst_n = 1'b0;
        start1 = 1'b0; ch1 = 2'd0; win1 = 16'd0;
        start2 = 1'b0; ch2 = 2'd0; win2 = 16'd0;
        per[0] = 4; per[1] = 6; per[2] = 8; per[3] = 10;
        repeat (5) tick();
        check("rst_init", {28'd0, init1}, 32'hF);
        check("rst_busy", {31'd0, busy1}, 0);
        check("rst_done", {31'd0, done1}, 0);
        check("rst_count", count1, 0);
        check("rst_ovf", {31'd0, ovf1}, 0);
        rst_n = 1'b1;
        nd = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (done1 === 1'b1 || busy1 !== 1'b0 || init1 !== 4'hF) nd++;
        end
        check("idle_stable", nd, 0);
        check("idle_count", count1, 0);

        // Basic: period-8 input on channel 2, 96-cycle window, START pulses and CH/WINDOW churn while busy
        per[0] = 0; per[1] = 0; per[2] = 8; per[3] = 0;
        run(1'b0, 2'd2, 16'd96, 1'b1, 1'b1, lat, nd, bad);
        check("basic_latency", lat, 105);
        check("basic_ndone", nd, 1);
        check("basic_count", count1, 12);
        check("basic_ovf", {31'd0, ovf1}, 0);
        check("basic_init", bad, 0);
        check("basic_idle_after", {31'd0, busy1}, 0);

        // Isolation: neighbours toggle, selected channel static low
        per[0] = 4; per[1] = 0; per[2] = 4; per[3] = 4;
        run(1'b0, 2'd1, 16'd50, 1'b0, 1'b0, lat, nd, bad);
        check("iso_latency", lat, 59);
        check("iso_count", count1, 0);
        check("iso_init", bad, 0);

        // Zero window: MEAS skipped
        run(1'b0, 2'd3, 16'd0, 1'b0, 1'b0, lat, nd, bad);
        check("w0_latency", lat, 9);
        check("w0_count", count1, 0);
        check("w0_ndone", nd, 1);
        check("w0_init", bad, 0);

        // Saturation on the 4-bit instance: 25 edges clip at 15
        per[0] = 4; per[1] = 0; per[2] = 0; per[3] = 0;
        run(1'b1, 2'd0, 16'd100, 1'b0, 1'b0, lat, nd, bad);
        check("sat_latency", lat, 109);
        check("sat_count", {28'd0, count2}, 15);
        check("sat_ovf", {31'd0, ovf2}, 1);
        check("sat_init", bad, 0);
        start2 = 1'b1; win2 = 16'd0;
        tick();
        start2 = 1'b0;
        check("sat_ovf_cleared", {31'd0, ovf2}, 0);
        check("sat_count_cleared", {28'd0, count2}, 0);
        repeat (20) tick();
        check("sat_idle_after", {31'd0, busy2}, 0);

        // Reset 40 cycles into MEAS
        per[0] = 0; per[1] = 0; per[2] = 8; per[3] = 0;
        ch1 = 2'd2; win1 = 16'd96; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (48) tick();
        check("mid_busy", {31'd0, busy1}, 1);
        check("mid_init", {28'd0, init1}, 32'hB);
        rst_n = 1'b0;
        #1;
        check("mrst_init", {28'd0, init1}, 32'hF);
        check("mrst_busy", {31'd0, busy1}, 0);
        check("mrst_done", {31'd0, done1}, 0);
        check("mrst_count", count1, 0);
        check("mrst_ovf", {31'd0, ovf1}, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        nd = 0;
        for (int n = 0; n < 120; n++) begin
            tick();
            if (done1 === 1'b1) nd++;
        end
        check("mrst_no_done", nd, 0);
        run(1'b0, 2'd2, 16'd96, 1'b0, 1'b0, lat, nd, bad);
        check("post_rst_latency", lat, 105);
        check("post_rst_count", count1, 12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
